pattern_seq_gen: RTL and testbench

Parametrised pattern sequence generator with a fixed-latency delay line. It is the next generation of the SHA_256 design's shift/inverting-delay pattern source. It adds W-bit width, selectable sequence mode (Johnson, ring, Galois LFSR, hold), seed load, step enable, period detection with a step counter, and a DEPTH-stage delayed output with a valid flag and optional inversion. It sits beside the SHA_256 datapath as a test-pattern and schedule-token source.

---
 rtl/pattern_seq_gen.sv | 108 ++++++++++
 tb/tb_pattern_seq_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_seq_gen.sv
// Parametrised pattern sequence generator (Johnson / ring / Galois LFSR / hold)
// with wrap detection, step counter and a fixed-latency DEPTH-stage delayed output.
module pattern_seq_gen #(
  parameter int           W       = 8,
  parameter int           DEPTH   = 3,
  parameter logic [W-1:0] POLY    = 8'hB8,
  parameter bit           INV_OUT = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic [1:0]   mode_i,
  output logic [W-1:0] pat_o,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o,
  output logic [W-1:0] dly_o,
  output logic         dly_valid_o
);

  localparam logic [1:0] MODE_JOHNSON = 2'b00;
  localparam logic [1:0] MODE_RING    = 2'b01;
  localparam logic [1:0] MODE_LFSR    = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] pat_q;
  logic [W-1:0] ref_q;
  logic [W-1:0] cnt_q;
  logic         wrap_q;
  logic         seeded_q;

  logic [W-1:0] next_pat;
  logic [W-1:0] seed_eff;
  logic         step;

  logic [DEPTH-1:0] pv_q;
  logic [W-1:0]     pd_q [DEPTH];

  always_comb begin
    next_pat = pat_q;
    unique case (mode_i)
      MODE_JOHNSON: next_pat = {pat_q[W-2:0], ~pat_q[W-1]};
      MODE_RING:    next_pat = {pat_q[W-2:0], pat_q[W-1]};
      MODE_LFSR:    next_pat = (pat_q >> 1) ^ (pat_q[0] ? POLY : '0);
      MODE_HOLD:    next_pat = pat_q;
      default:      next_pat = pat_q;
    endcase
  end

  // An all-zero LFSR seed would lock up the register, so it is replaced by 1.
  assign seed_eff = ((mode_i == MODE_LFSR) && (seed_i == '0)) ? ONE : seed_i;
  assign step     = en_i & ~load_i & seeded_q & (mode_i != MODE_HOLD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pat_q    <= '0;
      ref_q    <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      seeded_q <= 1'b0;
    end else if (load_i) begin
      pat_q    <= seed_eff;
      ref_q    <= seed_eff;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      seeded_q <= 1'b1;
    end else if (step) begin
      pat_q <= next_pat;
      if (next_pat == ref_q) begin
        cnt_q  <= '0;
        wrap_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
        wrap_q <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  // Delay line shifts every cycle; stage 0 samples the registered pattern and seeded flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pv_q <= '0;
      for (int k = 0; k < DEPTH; k++) pd_q[k] <= '0;
    end else begin
      pv_q[0] <= seeded_q;
      pd_q[0] <= pat_q;
      for (int k = 1; k < DEPTH; k++) begin
        pv_q[k] <= pv_q[k-1];
        pd_q[k] <= pd_q[k-1];
      end
    end
  end

  // dly_valid_o qualifies dly_o every cycle; there is no backpressure, so a
  // consumer must take dly_o in any cycle where dly_valid_o is high.
  assign dly_valid_o = pv_q[DEPTH-1];
  assign dly_o       = pv_q[DEPTH-1] ? (INV_OUT ? ~pd_q[DEPTH-1] : pd_q[DEPTH-1]) : '0;

  assign pat_o  = pat_q;
  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Scoreboard bench for pattern_seq_gen: directed stimulus pushes hand-computed
// expectations; a negedge monitor pops and compares them against the outputs.
module tb_pattern_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [1:0] mode = 2'b00;

  logic [7:0] pat, cnt, dly;
  logic       wrap, dv;
  logic [7:0] pat2, cnt2, dly2;
  logic       wrap2, dv2;

  always #5 clk = ~clk;

  pattern_seq_gen dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .seed_i(seed), .mode_i(mode),
    .pat_o(pat), .cnt_o(cnt), .wrap_o(wrap), .dly_o(dly), .dly_valid_o(dv)
  );

  pattern_seq_gen #(.INV_OUT(1'b0)) dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .seed_i(seed), .mode_i(mode),
    .pat_o(pat2), .cnt_o(cnt2), .wrap_o(wrap2), .dly_o(dly2), .dly_valid_o(dv2)
  );

  typedef struct packed {
    logic [7:0] tag;
    logic       pk;
    logic [7:0] pat;
    logic [7:0] cnt;
    logic       wrap;
    logic       dv;
    logic       dk;
    logic [7:0] dly;
    logic [7:0] dly2;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Expected delay-line contents, built only from the expected patterns below.
  logic       m_seeded = 1'b0;
  logic [7:0] m_pat = 8'h00;
  logic       m_pk = 1'b1;
  logic       hv[3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] hp[3] = '{8'h00, 8'h00, 8'h00};
  logic       hk[3] = '{1'b1, 1'b1, 1'b1};

  logic [7:0] john[16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                           8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [7:0] ring[8]  = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
  logic [7:0] lfsr[5]  = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
  logic [7:0] john5a[8] = '{8'hB5, 8'h6A, 8'hD5, 8'hAA, 8'h54, 8'hA9, 8'h52, 8'hA5};

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  // One clock cycle: drive inputs, then queue the expected post-edge outputs.
  task automatic cyc(input logic e, input logic ld, input logic [7:0] s, input logic [1:0] md,
                     input logic pk, input logic [7:0] p, input logic [7:0] c,
                     input logic wr, input logic [7:0] tag);
    exp_t ex;
    en = e; load = ld; seed = s; mode = md;
    @(posedge clk);
    #1;
    hv[2] = hv[1]; hp[2] = hp[1]; hk[2] = hk[1];
    hv[1] = hv[0]; hp[1] = hp[0]; hk[1] = hk[0];
    hv[0] = m_seeded; hp[0] = m_pat; hk[0] = m_pk;
    m_pat = p; m_pk = pk;
    if (ld) m_seeded = 1'b1;
    ex.tag  = tag;
    ex.pk   = pk;
    ex.pat  = p;
    ex.cnt  = c;
    ex.wrap = wr;
    ex.dv   = hv[2];
    ex.dk   = !hv[2] || hk[2];
    ex.dly  = hv[2] ? ~hp[2] : 8'h00;
    ex.dly2 = hv[2] ? hp[2] : 8'h00;
    exp_q.push_back(ex);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset(input logic [7:0] tag);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk($sformatf("t%0d rst pat", tag), pat, 8'h00);
    chk($sformatf("t%0d rst cnt", tag), cnt, 8'h00);
    chk($sformatf("t%0d rst wrap", tag), {7'd0, wrap}, 8'h00);
    chk($sformatf("t%0d rst dv", tag), {7'd0, dv}, 8'h00);
    chk($sformatf("t%0d rst dly", tag), dly, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    m_seeded = 1'b0; m_pat = 8'h00; m_pk = 1'b1;
    for (int k = 0; k < 3; k++) begin
      hv[k] = 1'b0; hp[k] = 8'h00; hk[k] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.pk) chk($sformatf("t%0d pat", e.tag), pat, e.pat);
      chk($sformatf("t%0d cnt", e.tag), cnt, e.cnt);
      chk($sformatf("t%0d wrap", e.tag), {7'd0, wrap}, {7'd0, e.wrap});
      chk($sformatf("t%0d dly_valid", e.tag), {7'd0, dv}, {7'd0, e.dv});
      chk($sformatf("t%0d dly_valid2", e.tag), {7'd0, dv2}, {7'd0, e.dv});
      if (e.dk) begin
        chk($sformatf("t%0d dly", e.tag), dly, e.dly);
        chk($sformatf("t%0d dly_noinv", e.tag), dly2, e.dly2);
      end
    end
  end

  initial begin
    do_reset(8'd0);

    // en before any load is ignored
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'h00, 8'h00, 1'b0, 8'd50);

    // Johnson from 0x00: period 16, cnt peaks at 15
    cyc(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 8'h00, 8'h00, 1'b0, 8'd1);
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, john[i], (i == 15) ? 8'd0 : 8'(i + 1), i == 15, 8'd1);

    // Ring from 0x81: two full laps
    cyc(1'b0, 1'b1, 8'h81, 2'b01, 1'b1, 8'h81, 8'h00, 1'b0, 8'd2);
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 1'b0, 8'h00, 2'b01, 1'b1, ring[i % 8], 8'((i + 1) % 8), (i % 8) == 7, 8'd2);

    // Ring from 0xFF: period 1
    cyc(1'b0, 1'b1, 8'hFF, 2'b01, 1'b1, 8'hFF, 8'h00, 1'b0, 8'd21);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 8'hFF, 8'h00, 1'b1, 8'd21);

    // LFSR from 0x01: wrap after exactly 255 steps
    cyc(1'b0, 1'b1, 8'h01, 2'b10, 1'b1, 8'h01, 8'h00, 1'b0, 8'd3);
    for (int i = 0; i < 255; i++)
      cyc(1'b1, 1'b0, 8'h00, 2'b10, (i < 5) || (i == 254), (i < 5) ? lfsr[i] : 8'h01,
          (i == 254) ? 8'd0 : 8'(i + 1), i == 254, 8'd3);

    // LFSR zero seed replaced by 1
    cyc(1'b0, 1'b1, 8'h00, 2'b10, 1'b1, 8'h01, 8'h00, 1'b0, 8'd31);

    // Delay line from a fresh reset, then Johnson steps and a flush
    do_reset(8'd4);
    cyc(1'b0, 1'b1, 8'h5A, 2'b00, 1'b1, 8'h5A, 8'h00, 1'b0, 8'd4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 8'h5A, 8'h00, 1'b0, 8'd4);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, john5a[i], 8'(i + 1), 1'b0, 8'd4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 8'hA5, 8'h08, 1'b0, 8'd4);

    // Load beats en; hold mode freezes pat and cnt
    cyc(1'b1, 1'b1, 8'h10, 2'b00, 1'b1, 8'h10, 8'h00, 1'b0, 8'd5);
    cyc(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'h21, 8'h01, 1'b0, 8'd5);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 8'h21, 8'h01, 1'b0, 8'd5);

    // Reset in the middle of an LFSR run; no stepping until a new load
    cyc(1'b0, 1'b1, 8'h01, 2'b10, 1'b1, 8'h01, 8'h00, 1'b0, 8'd6);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h00, 2'b10, 1'b1, lfsr[i], 8'(i + 1), 1'b0, 8'd6);
    do_reset(8'd6);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h00, 2'b10, 1'b1, 8'h00, 8'h00, 1'b0, 8'd6);

    @(negedge clk);
    #1;
    chk("scoreboard drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
